// File: rtl/call_return_stack_pkg.sv
// Shared frontend definitions: return-stack sizing defaults and the
// {count, tos_ptr} snapshot layout that travels with predicted branches.
package call_return_stack_pkg;

  localparam int unsigned IP_WIDTH  = 48;
  localparam int unsigned RAS_DEPTH = 16;
  localparam int unsigned RAS_PTR_W = 4;

  typedef struct packed {
    logic [RAS_PTR_W:0]   count;
    logic [RAS_PTR_W-1:0] tos_ptr;
  } ras_snap_t;

endpackage

// File: rtl/call_return_stack_ras_storage.sv
// Return-address array: one write port, one combinational read port.
// Contents are never reset; validity is tracked by the owner's count.
module ras_storage #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 48,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_return_stack.sv
// Circular return-address stack with saturating occupancy, wrap-around on
// overflow, same-cycle pop-then-push, and snapshot-based mispredict restore.
module call_return_stack #(
  parameter int unsigned DEPTH    = call_return_stack_pkg::RAS_DEPTH,
  parameter int unsigned IP_WIDTH = call_return_stack_pkg::IP_WIDTH,
  parameter int unsigned PTR_W    = call_return_stack_pkg::RAS_PTR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [IP_WIDTH-1:0] push_addr,
  input  logic                restore,
  input  logic [2*PTR_W:0]    restore_snap,
  output logic [IP_WIDTH-1:0] ret_addr,
  output logic                ret_valid,
  output logic [2*PTR_W:0]    snap,
  output logic                full
);

  localparam int unsigned   CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [PTR_W-1:0]    tos_q, tos_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IP_WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic                ret_valid_q, ret_valid_d;
  logic                we;
  logic [PTR_W-1:0]    waddr;
  logic [IP_WIDTH-1:0] rdata;
  logic                empty;
  logic [CNT_W-1:0]    rs_count;

  assign empty    = (count_q == '0);
  assign rs_count = restore_snap[2*PTR_W:PTR_W];

  ras_storage #(
    .DEPTH (DEPTH),
    .WIDTH (IP_WIDTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_addr),
    .raddr (tos_q),
    .rdata (rdata)
  );

  // Restore wins over push/pop; simultaneous push+pop replaces the top in place.
  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    ret_addr_d  = ret_addr_q;
    ret_valid_d = 1'b0;
    we          = 1'b0;
    waddr       = tos_q;
    if (restore) begin
      tos_d   = restore_snap[PTR_W-1:0];
      count_d = (rs_count > CNT_MAX) ? CNT_MAX : rs_count;
    end else if (push && pop) begin
      we = 1'b1;
      if (!empty) begin
        ret_addr_d  = rdata;
        ret_valid_d = 1'b1;
      end else begin
        count_d = CNT_W'(1);
      end
    end else if (push) begin
      we    = 1'b1;
      tos_d = tos_q + PTR_W'(1);
      waddr = tos_d;
      if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ret_addr_d  = rdata;
      ret_valid_d = 1'b1;
      tos_d       = tos_q - PTR_W'(1);
      count_d     = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_q       <= '0;
      count_q     <= '0;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      count_q     <= count_d;
      ret_addr_q  <= ret_addr_d;
      ret_valid_q <= ret_valid_d;
    end
  end

  assign ret_addr  = ret_addr_q;
  assign ret_valid = ret_valid_q;
  assign snap      = {count_q, tos_q};
  assign full      = (count_q == CNT_MAX);

endmodule

// File: tb/tb_call_return_stack.sv
// Self-checking bench for call_return_stack: directed scenarios plus a
// randomized push/pop run against a queue-based return-stack model.
module tb_call_return_stack;
  import call_return_stack_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IPW   = 48;
  localparam int unsigned PTR_W = 4;

  logic             clk;
  logic             rst;
  logic             push;
  logic             pop;
  logic [IPW-1:0]   push_addr;
  logic             restore;
  logic [2*PTR_W:0] restore_snap;
  logic [IPW-1:0]   ret_addr;
  logic             ret_valid;
  logic [2*PTR_W:0] snap;
  logic             full;

  int n_cmp = 0;
  int n_mis = 0;

  call_return_stack #(
    .DEPTH    (DEPTH),
    .IP_WIDTH (IPW),
    .PTR_W    (PTR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .push_addr    (push_addr),
    .restore      (restore),
    .restore_snap (restore_snap),
    .ret_addr     (ret_addr),
    .ret_valid    (ret_valid),
    .snap         (snap),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given controls; returns #1 after the rising edge.
  task automatic cyc(input bit p, input bit o, input logic [IPW-1:0] a,
                     input bit r, input logic [2*PTR_W:0] rs);
    push = p; pop = o; push_addr = a; restore = r; restore_snap = rs;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; restore = 1'b0;
  endtask

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; restore = 1'b0; push_addr = '0; restore_snap = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic logic [8:0] mk_snap(input int cnt, input int tos);
    ras_snap_t s;
    s.count   = 5'(cnt);
    s.tos_ptr = 4'(tos);
    return s;
  endfunction

  // Reference model: newest entry at the back of the queue.
  logic [IPW-1:0] mq[$];
  int             m_tos;

  task automatic model_step(input bit p, input bit o, input logic [IPW-1:0] a,
                            output bit ev, output logic [IPW-1:0] ea);
    ev = 1'b0; ea = '0;
    if (p && o) begin
      if (mq.size() > 0) begin
        ev = 1'b1; ea = mq[mq.size()-1]; mq[mq.size()-1] = a;
      end else begin
        mq.push_back(a);
      end
    end else if (p) begin
      mq.push_back(a);
      if (mq.size() > DEPTH) void'(mq.pop_front());
      m_tos = (m_tos + 1) % DEPTH;
    end else if (o && mq.size() > 0) begin
      ev = 1'b1; ea = mq.pop_back();
      m_tos = (m_tos + DEPTH - 1) % DEPTH;
    end
  endtask

  initial begin
    logic [2*PTR_W:0] cap;
    bit               ev;
    logic [IPW-1:0]   ea;
    int               bias;

    rst = 1'b0;
    do_reset();

    // Reset state and underflow on empty
    chk("rst_valid", 64'(ret_valid), 64'd0);
    chk("rst_addr", 64'(ret_addr), 64'd0);
    chk("rst_snap", 64'(snap), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    cyc(0, 1, '0, 0, '0);
    chk("empty_pop_valid", 64'(ret_valid), 64'd0);
    chk("empty_pop_snap", 64'(snap), 64'd0);

    // LIFO order over three calls
    do_reset();
    cyc(1, 0, 48'h1000, 0, '0);
    cyc(1, 0, 48'h2000, 0, '0);
    cyc(1, 0, 48'h3000, 0, '0);
    chk("lifo_snap", 64'(snap), 64'(mk_snap(3, 3)));
    cyc(0, 1, '0, 0, '0);
    chk("lifo_v0", 64'(ret_valid), 64'd1); chk("lifo_a0", 64'(ret_addr), 64'h3000);
    cyc(0, 1, '0, 0, '0);
    chk("lifo_v1", 64'(ret_valid), 64'd1); chk("lifo_a1", 64'(ret_addr), 64'h2000);
    cyc(0, 1, '0, 0, '0);
    chk("lifo_v2", 64'(ret_valid), 64'd1); chk("lifo_a2", 64'(ret_addr), 64'h1000);
    chk("lifo_snap_end", 64'(snap), 64'd0);
    cyc(0, 0, '0, 0, '0);
    chk("lifo_valid_drop", 64'(ret_valid), 64'd0);

    // Overflow wraps onto the oldest entry
    do_reset();
    for (int i = 1; i <= 17; i++) cyc(1, 0, IPW'(i), 0, '0);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_snap", 64'(snap), 64'(mk_snap(16, 1)));
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, '0, 0, '0);
      chk("ovf_pop_v", 64'(ret_valid), 64'd1);
      chk("ovf_pop_a", 64'(ret_addr), 64'(17 - i));
    end
    cyc(0, 1, '0, 0, '0);
    chk("ovf_under_v", 64'(ret_valid), 64'd0);
    chk("ovf_under_full", 64'(full), 64'd0);

    // Same-cycle push and pop
    do_reset();
    cyc(1, 0, 48'hA, 0, '0);
    cyc(1, 0, 48'hB, 0, '0);
    cyc(1, 1, 48'hC, 0, '0);
    chk("pp_v", 64'(ret_valid), 64'd1); chk("pp_a", 64'(ret_addr), 64'hB);
    chk("pp_snap", 64'(snap), 64'(mk_snap(2, 2)));
    cyc(0, 1, '0, 0, '0);
    chk("pp_next_a", 64'(ret_addr), 64'hC);
    cyc(0, 1, '0, 0, '0);
    chk("pp_last_v", 64'(ret_valid), 64'd1); chk("pp_last_a", 64'(ret_addr), 64'hA);
    do_reset();
    cyc(1, 1, 48'h55, 0, '0);
    chk("pp_empty_v", 64'(ret_valid), 64'd0);
    chk("pp_empty_snap", 64'(snap), 64'(mk_snap(1, 0)));

    // Snapshot restore and clamping
    do_reset();
    cyc(1, 0, 48'hA, 0, '0);
    cap = snap;
    chk("cap_snap", 64'(cap), 64'(mk_snap(1, 1)));
    cyc(1, 0, 48'hB, 0, '0);
    cyc(0, 1, '0, 0, '0);
    cyc(0, 1, '0, 0, '0);
    cyc(1, 1, 48'hDEAD, 1, cap);
    chk("rest_v", 64'(ret_valid), 64'd0);
    chk("rest_snap", 64'(snap), 64'(cap));
    cyc(0, 1, '0, 0, '0);
    chk("rest_pop_v", 64'(ret_valid), 64'd1); chk("rest_pop_a", 64'(ret_addr), 64'hA);
    cyc(0, 0, '0, 1, 9'h1F3);
    chk("clamp_snap", 64'(snap), 64'(mk_snap(16, 3)));
    chk("clamp_full", 64'(full), 64'd1);

    // Reset during a pop result
    do_reset();
    cyc(1, 0, 48'h5, 0, '0);
    cyc(1, 0, 48'h6, 0, '0);
    cyc(0, 1, '0, 0, '0);
    chk("mid_pre_v", 64'(ret_valid), 64'd1); chk("mid_pre_a", 64'(ret_addr), 64'h6);
    rst = 1'b0; #1;
    chk("mid_rst_v", 64'(ret_valid), 64'd0);
    chk("mid_rst_snap", 64'(snap), 64'd0);
    chk("mid_rst_addr", 64'(ret_addr), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    cyc(0, 1, '0, 0, '0);
    chk("mid_after_v", 64'(ret_valid), 64'd0);

    // Randomized push/pop against the queue model
    do_reset();
    mq.delete(); m_tos = 0;
    bias = 50;
    for (int c = 0; c < 800; c++) begin
      bit             p, o;
      logic [IPW-1:0] a;
      if (c % 64 == 0) bias = int'($urandom_range(15, 85));
      p = ($urandom_range(0, 99) < bias);
      o = ($urandom_range(0, 99) < (100 - bias));
      a = IPW'({$urandom, $urandom});
      model_step(p, o, a, ev, ea);
      cyc(p, o, a, 0, '0);
      chk("rnd_valid", 64'(ret_valid), 64'(ev));
      if (ev) chk("rnd_addr", 64'(ret_addr), 64'(ea));
      chk("rnd_snap", 64'(snap), 64'(mk_snap(mq.size(), m_tos)));
      chk("rnd_full", 64'(full), 64'(mq.size() == DEPTH));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/call_return_stack.md
CALL_RETURN_STACK -- requirements
Module: call_return_stack

Interface
REQ-001 Parameter DEPTH, default 16: number of return-address entries; power of two.
REQ-002 Parameter IP_WIDTH, default 48: instruction-pointer width.
REQ-003 Parameter PTR_W, default 4: log2(DEPTH).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 push  in  1  call decoded; same meaning as the decoder's pushCallStack.
REQ-007 pop  in  1  return decoded; same meaning as the decoder's popCallStack.
REQ-008 push_addr  in  IP_WIDTH  return IP of the call (address of next instruction); bit 0 is stored as given.
REQ-009 restore  in  1  mispredict recovery strobe.
REQ-010 restore_snap  in  PTR_W+PTR_W+1  snapshot to restore: {count, tos_ptr}.
REQ-011 ret_addr  out  IP_WIDTH  predicted return target, registered.
REQ-012 ret_valid  out  1  ret_addr is valid; one-cycle pulse.
REQ-013 snap  out  PTR_W+PTR_W+1  current {count, tos_ptr}, combinational from state, for attachment to the branch.
REQ-014 full  out  1  count==DEPTH.

Function
REQ-015 Storage: DEPTH x IP_WIDTH circular array; tos_ptr indexes the top entry; count saturates at DEPTH.
REQ-016 Push only: tos_ptr+1 mod DEPTH; write push_addr at the new tos_ptr; count+1, saturating at DEPTH.
REQ-017 Push when full: overwrite the oldest entry (wrap-around); count stays DEPTH.
REQ-018 Pop only, count>0: ret_addr<=entry[tos_ptr]; ret_valid<=1 next cycle; tos_ptr-1 mod DEPTH; count-1.
REQ-019 Pop only, count==0: ret_valid<=0; ret_addr holds; tos_ptr and count unchanged (underflow, no wrap).
REQ-020 Push and pop in the same cycle: pop is ordered first, then push. ret_addr<=old entry[tos_ptr], with ret_valid=(count>0). push_addr is written at the same slot. tos_ptr and count are unchanged; if count was 0, count becomes 1 and tos_ptr is unchanged.
REQ-021 restore: tos_ptr<=restore_snap[PTR_W-1:0] and count<=restore_snap[upper]. Array contents are untouched. Same-cycle push and pop are ignored. ret_valid<=0.
REQ-022 restore_snap count > DEPTH: clamp to DEPTH.
REQ-023 ret_valid is deasserted in every cycle without a qualifying pop.
REQ-024 Latency: pop to ret_addr/ret_valid is exactly 1 cycle; push data is readable by a pop in the next cycle.
REQ-025 snap reflects the state before the current cycle's update.

Reset
REQ-026 On rst low, asynchronously: tos_ptr=0, count=0, ret_valid=0, ret_addr=0, full=0.
REQ-027 Array contents are not reset; count=0 guarantees no stale entry is ever reported valid.
REQ-028 Reset asserted mid-operation discards any in-flight pop result; the first cycle after release behaves as an empty stack.

Structure
REQ-029 IP_WIDTH, the RAS snapshot packed typedef {count, tos_ptr}, and DEPTH default constants shall live in the shared package with other frontend definitions.
REQ-030 One sub-module, ras_storage: a 1-write/1-read register array with no reset, instantiated once; all pointer and count logic stays in call_return_stack.

Verification
REQ-031 Push 0x1000, 0x2000, 0x3000, then 3 pops -> ret_addr 0x3000, 0x2000, 0x1000 on consecutive cycles, each with ret_valid=1; count ends at 0.
REQ-032 Pop on an empty stack after reset -> ret_valid=0, snap=0, no pointer movement.
REQ-033 17 pushes of 1..17 (DEPTH=16) -> full=1; 16 pops return 17..2; the 17th pop gives ret_valid=0.
REQ-034 Stack holds {0xA,0xB}; push 0xC with pop in the same cycle -> ret_addr=0xB, ret_valid=1; next pop returns 0xC, then 0xA.
REQ-035 Capture snap after pushing 0xA; push 0xB, pop, pop, then assert restore with the captured snap -> next pop returns 0xA with ret_valid=1.
REQ-036 Assert rst during a pop cycle -> ret_valid=0 immediately, count=0; a pop after release gives ret_valid=0.
